// File: rtl/barret_rr_sched_2143.sv
// Round-robin scheduler feeding a shared 2-stage mod-2143 Barrett reducer, with ID-tagged responses.
// Optional macro BARRET_RANGE_CHECK_EN flags operands >= 2143^2 (rsp_err=1, rsp_data=0).
module barret_rr_sched_2143 #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned Q       = 2143,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [23*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [11:0]           rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic                  busy
);

  if (Q != 2143 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_cfg_chk
    $error("barret_rr_sched_2143: unsupported Q or NUM_REQ");
  end

  // run_q gives a synchronous release: no grants until the first edge after rst_n rises
  logic           run_q;
  logic           a_valid_q;
  logic [22:0]    a_q;
  logic [IDW-1:0] a_id_q;
  logic           b_valid_q;
  logic [11:0]    b_data_q;
  logic [IDW-1:0] b_id_q;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic               b_adv, a_adv;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     idx;
  logic [NUM_REQ-1:0] gnt;
  logic [22:0]        sel_a;

  assign b_adv = !b_valid_q || rsp_ready;
  assign a_adv = !a_valid_q || b_adv;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    gnt     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (run_q && a_adv && !gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
    if (!gnt_any)                          ptr_d = ptr_q;
    else if (gnt_id == IDW'(NUM_REQ - 1))  ptr_d = '0;
    else                                   ptr_d = gnt_id + 1'b1;
  end

  assign req_ready = gnt;
  assign sel_a     = req_data[32'(gnt_id)*23 +: 23];

  // q1*7828 can exceed 23 bits for in-range operands, so the product is carried at 24 bits
  logic [10:0] q1;
  logic [23:0] prod, tq, r0;
  logic [11:0] t, red;

  always_comb begin
    q1   = a_q[22:12];
    prod = 24'(q1) * 24'd7828;
    t    = 12'(prod >> 12);
    tq   = 24'(t) * 24'd2143;
    r0   = {1'b0, a_q} - tq;
    red  = (r0 >= 24'd2143) ? 12'(r0 - 24'd2143) : r0[11:0];
  end

`ifdef BARRET_RANGE_CHECK_EN
  logic a_err_q, b_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
    end else begin
      if (gnt_any) a_err_q <= (sel_a >= 23'd4592449);
      if (b_adv && a_valid_q) b_err_q <= a_err_q;
    end
  end

  assign rsp_err  = b_err_q;
  assign rsp_data = b_err_q ? 12'd0 : b_data_q;
`else
  assign rsp_err  = 1'b0;
  assign rsp_data = b_data_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      ptr_q     <= '0;
      a_valid_q <= 1'b0;
      a_q       <= '0;
      a_id_q    <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_id_q    <= '0;
    end else begin
      run_q <= 1'b1;
      ptr_q <= ptr_d;
      if (a_adv) begin
        a_valid_q <= gnt_any;
        if (gnt_any) begin
          a_q    <= sel_a;
          a_id_q <= gnt_id;
        end
      end
      if (b_adv) begin
        b_valid_q <= a_valid_q;
        if (a_valid_q) begin
          b_data_q <= red;
          b_id_q   <= a_id_q;
        end
      end
    end
  end

  assign rsp_valid = b_valid_q;
  assign rsp_id    = b_id_q;
  assign busy      = a_valid_q | b_valid_q;

endmodule

// File: tb/tb_barret_rr_sched_2143.sv
// Scoreboard bench for barret_rr_sched_2143: cycle model of arbitration/pipeline plus directed cases.
module tb_barret_rr_sched_2143;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [23*N-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [11:0]      rsp_data;
  logic [IDW-1:0]   rsp_id;
  logic             rsp_err;
  logic             busy;

  barret_rr_sched_2143 #(.NUM_REQ(N), .Q(2143)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int unsigned barrett(input int unsigned a);
    int unsigned q1, t, r0;
    q1 = a >> 12;
    t  = (q1 * 7828) >> 12;
    r0 = a - t * 2143;
    if (r0 >= 2143) r0 = r0 - 2143;
    return r0 & 32'hFFF;
  endfunction

  typedef struct {
    int unsigned data;
    int unsigned id;
    bit          err;
    bit          chk_data;
  } exp_t;

  exp_t        expq[$];
  int unsigned src[N][$];
  bit          take[N];
  int unsigned id_log[$];
  int unsigned last_data, last_id, last_err, nrsp = 0;

  // model state
  bit             m_av, m_bv, m_run, m_gv, m_aadv, m_badv;
  int unsigned    m_ptr, m_g, m_a;
  logic [N-1:0]   m_rdy;
  exp_t           ne, pe;
  bit             prev_hold;
  logic [14:0]    prev_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_val("reset_outs", {rsp_valid, busy, req_ready, rsp_data, rsp_id, rsp_err}, '0);
      m_av = 0; m_bv = 0; m_run = 0; m_ptr = 0;
      expq.delete();
      prev_hold = 0;
      for (int unsigned i = 0; i < N; i++) take[i] = 0;
    end else begin
      m_badv = !m_bv || rsp_ready;
      m_aadv = !m_av || m_badv;
      m_gv = 0; m_g = 0;
      if (m_run && m_aadv)
        for (int unsigned k = 0; k < N; k++)
          if (!m_gv && req_valid[(m_ptr + k) % N]) begin
            m_gv = 1;
            m_g  = (m_ptr + k) % N;
          end
      m_rdy = '0;
      if (m_gv) m_rdy[m_g] = 1'b1;
      check_val("req_ready", req_ready, m_rdy);
      check_val("rsp_valid", rsp_valid, m_bv);
      check_val("busy", busy, m_av | m_bv);
      if (prev_hold) check_val("rsp_hold", {rsp_data, rsp_id, rsp_err}, prev_out);
      if (m_bv && rsp_ready) begin
        check_val("q_nonempty", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          pe = expq.pop_front();
          check_val("rsp_id", rsp_id, pe.id);
          check_val("rsp_err", rsp_err, pe.err);
          if (pe.chk_data) check_val("rsp_data", rsp_data, pe.data);
        end
        last_data = rsp_data; last_id = rsp_id; last_err = rsp_err;
        id_log.push_back(rsp_id);
        nrsp++;
      end
      prev_hold = m_bv && !rsp_ready;
      prev_out  = {rsp_data, rsp_id, rsp_err};
      if (m_badv) m_bv = m_av;
      if (m_aadv) m_av = m_gv;
      if (m_gv) begin
        m_a = req_data[m_g*23 +: 23];
        ne.id = m_g;
`ifdef BARRET_RANGE_CHECK_EN
        ne.err = (m_a >= 4592449);
        ne.data = ne.err ? 0 : barrett(m_a);
        ne.chk_data = 1;
`else
        ne.err = 0;
        ne.data = barrett(m_a);
        ne.chk_data = (m_a < 4592449);
`endif
        expq.push_back(ne);
        take[m_g] = 1;
        m_ptr = (m_g + 1) % N;
      end
      m_run = 1;
    end
  end

  // requester driver: each requester presents the head of its queue until granted
  always @(posedge clk) begin
    #1;
    for (int unsigned i = 0; i < N; i++) begin
      if (take[i]) begin
        take[i] = 0;
        if (src[i].size() != 0) void'(src[i].pop_front());
      end
      req_valid[i] = (src[i].size() != 0);
      req_data[i*23 +: 23] = (src[i].size() != 0) ? 23'(src[i][0]) : '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit srcs_empty();
    for (int unsigned i = 0; i < N; i++) if (src[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain();
    int unsigned n = 0;
    while ((!srcs_empty() || expq.size() != 0) && n < 2000) begin
      step();
      n++;
    end
    step();
    check_val("drain_in_time", n < 2000, 1);
  endtask

  int unsigned bnd_a[4] = '{0, 2143, 2142, 4592448};
  int unsigned bnd_r[4] = '{0, 0, 2142, 2142};
  int unsigned n0;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '0; req_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // round robin from pointer 0
    rsp_ready = 1'b1;
    id_log.delete();
    for (int unsigned i = 0; i < N; i++) begin
      src[i].push_back(100 + i);
      src[i].push_back(5000 + 7 * i);
    end
    drain();
    check_val("rr_count", id_log.size(), 8);
    for (int unsigned i = 0; i < 8; i++)
      if (i < id_log.size()) check_val("rr_order", id_log[i], i % N);

    // single request
    src[0].push_back(5000);
    drain();
    check_val("single_data", last_data, 714);
    check_val("single_id", last_id, 0);

    // boundaries
    for (int unsigned i = 0; i < 4; i++) begin
      src[1].push_back(bnd_a[i]);
      drain();
      check_val("bnd_data", last_data, bnd_r[i]);
      check_val("bnd_err", last_err, 0);
      check_val("bnd_id", last_id, 1);
    end

    // backpressure
    n0 = nrsp;
    rsp_ready = 1'b0;
    for (int unsigned i = 0; i < N; i++)
      for (int unsigned j = 0; j < 6; j++) src[i].push_back($urandom_range(4592448, 0));
    repeat (5) step();
    check_val("bp_busy", busy, 1);
    check_val("bp_rsp_valid", rsp_valid, 1);
    check_val("bp_req_ready", req_ready, 0);
    rsp_ready = 1'b1;
    drain();
    check_val("bp_no_loss", nrsp - n0, 24);

    // reset mid-stream with both stages occupied
    for (int unsigned i = 0; i < N; i++)
      for (int unsigned j = 0; j < 4; j++) src[i].push_back(1000 + j);
    repeat (4) step();
    check_val("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    for (int unsigned i = 0; i < N; i++) src[i].delete();
    #1;
    check_val("async_rsp_valid", rsp_valid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    n0 = nrsp;
    repeat (5) step();
    check_val("no_stale_rsp", nrsp - n0, 0);

    // out-of-range operand
    src[2].push_back(8388607);
    drain();
    check_val("range_id", last_id, 2);
`ifdef BARRET_RANGE_CHECK_EN
    check_val("range_err", last_err, 1);
    check_val("range_data", last_data, 0);
`else
    check_val("range_err", last_err, 0);
`endif

    // random traffic with random backpressure
    for (int unsigned c = 0; c < 400; c++) begin
      for (int unsigned i = 0; i < N; i++)
        if ($urandom_range(3, 0) == 0 && src[i].size() < 3)
          src[i].push_back($urandom_range(4592448, 0));
      rsp_ready = ($urandom_range(2, 0) != 0);
      step();
    end
    rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
